// File: rtl/iterative_alu.sv
// Multi-cycle ALU: single-cycle basic ops, bit-serial multiply (shift-add)
// and restoring divide, both finishing in WIDTH iteration cycles.
module iterative_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             long_in;
  logic             last_iter;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH-1:0] basic_res;
  logic [WIDTH-1:0] res_nxt;
  logic             res_load;
  logic             slt_lt;

  // One shift-add step: {hi,lo} is the partial product with the multiplier
  // occupying the not-yet-consumed low bits.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] mcand);
    logic [WIDTH:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    return {sum, lo[WIDTH-1:1]};
  endfunction

  // One restoring-divide step: hi is the running remainder, lo shifts the
  // dividend out at the top and the quotient in at the bottom. A zero divisor
  // naturally yields an all-ones quotient and a remainder equal to the dividend.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] dvsr);
    logic [WIDTH:0] shifted;
    shifted = {hi, lo[WIDTH-1]};
    if (shifted >= {1'b0, dvsr})
      return {shifted[WIDTH-1:0] - dvsr, lo[WIDTH-2:0], 1'b1};
    else
      return {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
  endfunction

  assign long_in   = ALUControl[3] & ~ALUControl[2];
  assign last_iter = (state == CALC) && (cnt == CNT_LAST);
  assign slt_lt    = $signed(SrcA) < $signed(SrcB);

  // Single-cycle operations, evaluated straight from the ports at accept time
  always_comb begin
    basic_res = '0;
    case (ALUControl)
      4'b0000: basic_res = SrcA + SrcB;
      4'b0001: basic_res = SrcA - SrcB;
      4'b0010: basic_res = SrcA & SrcB;
      4'b0011: basic_res = SrcA | SrcB;
      4'b0101: basic_res = {{(WIDTH-1){1'b0}}, slt_lt};
      default: basic_res = '0;
    endcase
  end

  // Next iteration of the shared hi/lo accumulator (op_sel[1]: divide)
  always_comb begin
    if (op_sel[1]) {hi_nxt, lo_nxt} = div_step(acc_hi, acc_lo, opnd);
    else           {hi_nxt, lo_nxt} = mul_step(acc_hi, acc_lo, opnd);
  end

  // Result selection: MULHU/REMU take the high half, MUL/DIVU the low half
  always_comb begin
    res_load = 1'b0;
    res_nxt  = '0;
    if (accept && !long_in) begin
      res_load = 1'b1;
      res_nxt  = basic_res;
    end else if (last_iter) begin
      res_load = 1'b1;
      res_nxt  = op_sel[0] ? hi_nxt : lo_nxt;
    end
  end

  // FSM next state and status outputs
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          accept    = 1'b1;
          state_nxt = long_in ? CALC : DONE;
        end
      end
      CALC:    if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    Busy = (state != IDLE);
    Done = (state == DONE);
  end

  // State register and iteration counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == CALC) && !last_iter) cnt <= cnt + CW'(1);
      else                               cnt <= '0;
    end
  end

  // Operand capture and iterative datapath (no reset: contents are don't-care while idle)
  always_ff @(posedge clk) begin
    if (accept) begin
      op_sel <= ALUControl[1:0];
      acc_hi <= '0;
      if (ALUControl[1]) begin
        opnd   <= SrcB;
        acc_lo <= SrcA;
      end else begin
        opnd   <= SrcA;
        acc_lo <= SrcB;
      end
    end else if (state == CALC) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
    end
  end

  // Registered result and zero flag, written only on entry to DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResult <= '0;
      Zero      <= 1'b1;
    end else if (res_load) begin
      ALUResult <= res_nxt;
      Zero      <= (res_nxt == '0);
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Bench for iterative_alu: directed literal cases plus randomized traffic
// checked every cycle against a timing/arithmetic model.
module tb_iterative_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         Start = 1'b0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic [3:0]   ALUControl = '0;
  logic         Busy, Done, Zero;
  logic [W-1:0] ALUResult;

  int n_cmp  = 0;
  int n_fail = 0;

  iterative_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .Start(Start), .SrcA(SrcA), .SrcB(SrcB),
    .ALUControl(ALUControl), .Busy(Busy), .Done(Done),
    .ALUResult(ALUResult), .Zero(Zero)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0101: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'b1000: return p[W-1:0];
      4'b1001: return p[2*W-1:W];
      4'b1010: return (b == 0) ? {W{1'b1}} : a / b;
      4'b1011: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic bit is_long(input logic [3:0] op);
    return (op == 4'b1000) || (op == 4'b1001) || (op == 4'b1010) || (op == 4'b1011);
  endfunction

  // Model: an accepted op at edge s completes at edge d (s for basic, s+W for
  // long). Busy after edges s..d, Done after edge d; a new Start is taken only
  // once the edge before it is past d.
  longint       e = 0;
  longint       m_s = 0;
  longint       m_d = 0;
  bit           m_active = 1'b0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_res = '0;
  logic         m_zero = 1'b1;

  always @(posedge clk) begin
    e = e + 1;
    if (reset) begin
      m_active = 1'b0;
      m_res    = '0;
      m_zero   = 1'b1;
    end else begin
      if (Start && !(m_active && (e - 1) >= m_s && (e - 1) <= m_d)) begin
        m_active = 1'b1;
        m_s      = e;
        m_d      = is_long(ALUControl) ? e + W : e;
        m_pend   = ref_alu(ALUControl, SrcA, SrcB);
      end
      if (m_active && e == m_d) begin
        m_res  = m_pend;
        m_zero = (m_pend == '0);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy",   64'(Busy),      64'(m_active && e >= m_s && e <= m_d));
    chk("done",   64'(Done),      64'(m_active && e == m_d));
    chk("result", 64'(ALUResult), 64'(m_res));
    chk("zero",   64'(Zero),      64'(m_zero));
  end

  // ---------------- directed helpers ----------------
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    Start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    lat = 0;
    do begin
      @(negedge clk);
      Start = 1'b0;
      lat++;
    end while (!Done && lat < 100);
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_res"}, 64'(ALUResult), 64'(exp_res));
    chk({name, "_zero"}, 64'(Zero), 64'(exp_res == '0));
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom % 6)
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom % 16);
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [3:0] ops [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB,
                           4'h4, 4'h6, 4'h7, 4'hC, 4'hF};

  initial begin
    int dones, done_c;
    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_result", 64'(ALUResult), 64'd0);
    chk("rst_zero", 64'(Zero), 64'd1);
    reset = 1'b0;

    // Hand-computed cases
    run_op("add",      4'h0, 32'd20000, 32'd10000, 32'd30000, 1);
    chk("add_busy_after", 64'(Busy), 64'd1);
    run_op("sub",      4'h1, 32'd20000, 32'd20000, 32'd0, 1);
    run_op("slt",      4'h5, 32'hFFFFFFFF, 32'd1, 32'd1, 1);
    run_op("mul",      4'h8, 32'd20000, 32'd10000, 32'd200000000, 33);
    run_op("mulhu",    4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("divu0",    4'hA, 32'd20000, 32'd0, 32'hFFFFFFFF, 33);
    run_op("remu0",    4'hB, 32'd20000, 32'd0, 32'd20000, 33);
    run_op("divu3",    4'hA, 32'd20000, 32'd3, 32'd6666, 33);
    run_op("remu3",    4'hB, 32'd20000, 32'd3, 32'd2, 33);
    run_op("unused",   4'hE, 32'd5, 32'd7, 32'd0, 1);

    // Start during CALC and DONE must be ignored
    @(negedge clk);
    Start = 1'b1; ALUControl = 4'h8; SrcA = 32'd20000; SrcB = 32'd10000;
    dones = 0; done_c = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      Start = 1'b0;
      if (Done) begin dones++; done_c = c; end
      if (c == 5 || c == 33) begin
        Start = 1'b1; ALUControl = 4'h0; SrcA = 32'd1; SrcB = 32'd2;
      end
    end
    chk("ign_dones", 64'(dones), 64'd1);
    chk("ign_done_cycle", 64'(done_c), 64'd33);
    chk("ign_result", 64'(ALUResult), 64'd200000000);

    // Reset in the middle of a divide aborts it
    @(negedge clk);
    Start = 1'b1; ALUControl = 4'hA; SrcA = 32'd20000; SrcB = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      Start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_result", 64'(ALUResult), 64'd0);
    chk("abort_zero", 64'(Zero), 64'd1);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (Done) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    run_op("add_after_abort", 4'h0, 32'd1, 32'd2, 32'd3, 1);

    // Reset beats Start in the same cycle
    @(negedge clk);
    reset = 1'b1; Start = 1'b1; ALUControl = 4'h0; SrcA = 32'd4; SrcB = 32'd4;
    @(negedge clk);
    reset = 1'b0; Start = 1'b0;
    chk("rst_prio_busy", 64'(Busy), 64'd0);
    chk("rst_prio_done", 64'(Done), 64'd0);

    // Randomized traffic, checked by the per-cycle model comparison
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset      = (($urandom % 60) == 0);
      Start      = (($urandom % 2) == 0);
      ALUControl = ops[$urandom % 14];
      SrcA       = rnd_operand();
      SrcB       = rnd_operand();
    end
    @(negedge clk);
    reset = 1'b0; Start = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  request to begin an operation.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B.
- ALUControl  input  4  operation select.
- Busy  output  1  operation in progress; new Start ignored.
- Done  output  1  one-cycle pulse, ALUResult valid.
- ALUResult  output  WIDTH  registered result.
- Zero  output  1  registered, high when ALUResult is all zeros.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high, applied on clk rising edge.

Function
REQ-004 ALUControl encoding SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLT (signed, result 1/0), 1000 MUL (low WIDTH bits, unsigned), 1001 MULHU (high WIDTH bits of unsigned product), 1010 DIVU, 1011 REMU; all other codes are basic ops with result 0.
REQ-005 ADD/SUB SHALL wrap modulo 2^WIDTH; no carry or overflow output.
REQ-006 FSM states SHALL be IDLE, CALC, DONE; Busy = (state != IDLE).
REQ-007 In IDLE with Start=1, SrcA, SrcB and ALUControl SHALL be latched; later input changes SHALL NOT affect the operation.
REQ-008 Basic op accepted: IDLE -> DONE; result written at the same edge; Done high in the cycle immediately after the Start cycle.
REQ-009 MUL/MULHU/DIVU/REMU accepted: IDLE -> CALC; exactly WIDTH iteration cycles (shift-add multiply, restoring divide, one bit per cycle, internal counter 0..WIDTH-1); then -> DONE; Done high WIDTH+1 cycles after the Start cycle.
REQ-010 DONE SHALL last exactly one cycle with Done=1, then return to IDLE unconditionally.
REQ-011 ALUResult and Zero SHALL update only on entry to DONE and hold until the next result or reset.
REQ-012 Start in CALC or DONE SHALL be ignored (not queued); Start in IDLE during the cycle after DONE is accepted normally.
REQ-013 DIVU with SrcB=0 SHALL yield all ones; REMU with SrcB=0 SHALL yield SrcA; latency unchanged (WIDTH+1).
REQ-014 MUL/MULHU SHALL use a 2*WIDTH-bit internal product; no truncation before selection.
REQ-015 Done and Busy SHALL never both be low while an accepted operation is pending.

Reset
REQ-016 reset=1 SHALL force state IDLE, counter 0, ALUResult 0, Zero 1, Busy 0, Done 0 at the next rising edge.
REQ-017 reset asserted in CALC or DONE SHALL abort the operation; no Done pulse for the aborted op.
REQ-018 reset has priority over Start in the same cycle; Start is not accepted.

Verification (WIDTH=32)
REQ-019 ADD 20000, 10000 -> ALUResult=30000, Zero=0, Done exactly 1 cycle after Start, Busy high 1 cycle.
REQ-020 SUB 20000, 20000 -> ALUResult=0, Zero=1; SLT 0xFFFFFFFF, 1 -> ALUResult=1.
REQ-021 MUL 20000, 10000 -> 200000000 with Done 33 cycles after Start; MULHU 0xFFFFFFFF, 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-022 DIVU 20000, 0 -> 0xFFFFFFFF; REMU 20000, 0 -> 20000; DIVU 20000, 3 -> 6666; REMU 20000, 3 -> 2.
REQ-023 MUL started, then Start with ADD and changed SrcA/SrcB at cycles 5 and 33 -> both ignored, MUL result unchanged, single Done.
REQ-024 reset at cycle 10 of a DIVU -> Busy=0, Done never pulses, ALUResult=0, Zero=1; next ADD 1, 2 -> 3 in 1 cycle.
